// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and helpers for the bit-serial adder.
//   state_e    - controller state encoding (IDLE/RUN/DONE)
//   MAX_WIDTH  - largest supported operand width
//   fa_t       - one-bit full-adder result {cout, sum}
//   cnt_width  - bit-counter width for a given operand width (minimum 1)
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned MAX_WIDTH = 32;

  typedef struct packed {
    logic cout;
    logic sum;
  } fa_t;

  // Smallest w >= 1 with 2**w >= width, i.e. $clog2 clamped to 1.
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < MAX_WIDTH; i++) begin
      if ((32'd1 << i) < width) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_gate.sv
// full_adder_gate: one-bit full adder built from two half adders.
//   a, b - operand bits
//   ci   - carry in
//   s    - sum bit
//   co   - carry out
module full_adder_gate (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic hs1;
  logic hc1;
  logic hc2;

  // First half adder: a + b.
  assign hs1 = a ^ b;
  assign hc1 = a & b;

  // Second half adder: partial sum + carry in.
  assign s   = hs1 ^ ci;
  assign hc2 = hs1 & ci;

  // At most one half adder can generate a carry.
  assign co  = hc1 | hc2;

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one bit per clock.
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - operand handshake (a, b, cin); ready only in IDLE
//   out_valid/out_ready - result handshake (sum, cout); held until accepted
//   sum, cout           - {cout, sum} = a + b + cin, registered
//   busy                - high while an operation is in RUN or DONE
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned     CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state;
  state_e           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] a_sh_nxt;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] b_sh_nxt;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_sh_nxt;
  logic             carry;
  logic             carry_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             out_valid_nxt;
  logic             cout_nxt;

  logic             fa_s;
  logic             fa_co;
  fa_t              fa;

  // Single bit-slice: the LSBs of the shifters plus the running carry.
  full_adder_gate u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign fa = {fa_co, fa_s};

  // Next-state and datapath update.
  always_comb begin
    state_nxt     = state;
    a_sh_nxt      = a_sh;
    b_sh_nxt      = b_sh;
    sum_sh_nxt    = sum_sh;
    carry_nxt     = carry;
    cnt_nxt       = cnt;
    out_valid_nxt = out_valid;
    cout_nxt      = cout;

    case (state)
      IDLE: begin
        if (in_valid) begin
          a_sh_nxt  = a;
          b_sh_nxt  = b;
          carry_nxt = cin;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end

      RUN: begin
        // New sum bit enters at the MSB so the result lands LSB-aligned.
        sum_sh_nxt = (sum_sh >> 1) | (WIDTH'(fa.sum) << (WIDTH - 1));
        a_sh_nxt   = a_sh >> 1;
        b_sh_nxt   = b_sh >> 1;
        carry_nxt  = fa.cout;
        if (cnt == LAST) begin
          // Counter parks at LAST; it is cleared on the next load.
          state_nxt     = DONE;
          out_valid_nxt = 1'b1;
          cout_nxt      = fa.cout;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_nxt     = IDLE;
          out_valid_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt     = IDLE;
        out_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      cout      <= 1'b0;
    end else begin
      state     <= state_nxt;
      a_sh      <= a_sh_nxt;
      b_sh      <= b_sh_nxt;
      sum_sh    <= sum_sh_nxt;
      carry     <= carry_nxt;
      cnt       <= cnt_nxt;
      out_valid <= out_valid_nxt;
      cout      <= cout_nxt;
    end
  end

  assign sum      = sum_sh;
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomized checks of serial_adder at
// WIDTH = 1, 8 and 32 against an arithmetic reference model.
module tb_serial_adder;

  localparam int unsigned W0 = 1;
  localparam int unsigned W1 = 8;
  localparam int unsigned W2 = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  in_valid;
  logic [2:0]  out_ready;
  logic [2:0]  cin;
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];
  wire  [2:0]  in_ready;
  wire  [2:0]  out_valid;
  wire  [2:0]  cout;
  wire  [2:0]  busy;
  wire  [W0-1:0] s0;
  wire  [W1-1:0] s1;
  wire  [W2-1:0] s2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_v[0][W0-1:0]), .b(b_v[0][W0-1:0]), .cin(cin[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(s0), .cout(cout[0]), .busy(busy[0])
  );

  serial_adder #(.WIDTH(W1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_v[1][W1-1:0]), .b(b_v[1][W1-1:0]), .cin(cin[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(s1), .cout(cout[1]), .busy(busy[1])
  );

  serial_adder #(.WIDTH(W2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_v[2][W2-1:0]), .b(b_v[2][W2-1:0]), .cin(cin[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .sum(s2), .cout(cout[2]), .busy(busy[2])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sum_of(input int idx);
    case (idx)
      0:       return 32'(s0);
      1:       return 32'(s1);
      default: return s2;
    endcase
  endfunction

  function automatic int unsigned width_of(input int idx);
    case (idx)
      0:       return W0;
      1:       return W1;
      default: return W2;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on instance idx; stall = DONE cycles with
  // out_ready low; pulse = inject a stray in_valid during RUN.
  task automatic do_txn(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input int stall, input bit pulse);
    int unsigned w;
    logic [63:0] tot;
    logic [31:0] mask;
    logic [31:0] exp_s;
    logic        exp_c;
    int          n;
    w     = width_of(idx);
    mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    tot   = 64'(a & mask) + 64'(b & mask) + 64'(ci);
    exp_s = tot[31:0] & mask;
    exp_c = tot[w];

    check("idle_in_ready", 64'(in_ready[idx]), 64'd1);
    a_v[idx]       = a;
    b_v[idx]       = b;
    cin[idx]       = ci;
    in_valid[idx]  = 1'b1;
    out_ready[idx] = 1'($urandom);
    tick();
    in_valid[idx] = 1'b0;
    check("run_busy", 64'(busy[idx]), 64'd1);
    check("run_in_ready", 64'(in_ready[idx]), 64'd0);

    n = 0;
    while (!out_valid[idx] && n < int'(w) + 4) begin
      in_valid[idx] = pulse && (n == 1);
      if (pulse && n == 1) begin
        a_v[idx] = 32'd1;
        b_v[idx] = 32'd1;
      end
      out_ready[idx] = 1'($urandom);
      tick();
      n++;
    end
    in_valid[idx] = 1'b0;
    check("latency", 64'(n), 64'(w));
    check("out_valid", 64'(out_valid[idx]), 64'd1);
    check("sum", 64'(sum_of(idx)), 64'(exp_s));
    check("cout", 64'(cout[idx]), 64'(exp_c));

    for (int s = 0; s < stall; s++) begin
      out_ready[idx] = 1'b0;
      tick();
      check("stall_valid", 64'(out_valid[idx]), 64'd1);
      check("stall_sum", 64'(sum_of(idx)), 64'(exp_s));
      check("stall_cout", 64'(cout[idx]), 64'(exp_c));
    end

    out_ready[idx] = 1'b1;
    tick();
    out_ready[idx] = 1'b0;
    check("post_valid", 64'(out_valid[idx]), 64'd0);
    check("post_in_ready", 64'(in_ready[idx]), 64'd1);
    check("post_busy", 64'(busy[idx]), 64'd0);

    if (pulse) begin
      repeat (3) begin
        tick();
        check("no_second", 64'(out_valid[idx]), 64'd0);
        check("no_second_busy", 64'(busy[idx]), 64'd0);
      end
    end
  endtask

  // Reset state of one instance, sampled after a reset edge.
  task automatic check_reset(input int idx);
    check("rst_in_ready", 64'(in_ready[idx]), 64'd1);
    check("rst_out_valid", 64'(out_valid[idx]), 64'd0);
    check("rst_busy", 64'(busy[idx]), 64'd0);
    check("rst_sum", 64'(sum_of(idx)), 64'd0);
    check("rst_cout", 64'(cout[idx]), 64'd0);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    cin       = '0;
    for (int i = 0; i < 3; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) check_reset(i);

    // Directed cases at WIDTH=8.
    do_txn(1, 32'h5A, 32'h3C, 1'b0, 0, 1'b0);
    do_txn(1, 32'hFF, 32'h01, 1'b0, 0, 1'b0);
    do_txn(1, 32'hFF, 32'hFF, 1'b1, 0, 1'b0);
    do_txn(1, 32'h10, 32'h20, 1'b0, 5, 1'b0);
    do_txn(1, 32'h0F, 32'h01, 1'b0, 0, 1'b1);

    // Reset three cycles into RUN.
    a_v[1] = 32'h0F;
    b_v[1] = 32'h01;
    cin[1] = 1'b0;
    in_valid[1] = 1'b1;
    tick();
    in_valid[1] = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset(1);
    repeat (W1 + 2) begin
      tick();
      check("abort_no_pulse", 64'(out_valid[1]), 64'd0);
    end
    do_txn(1, 32'h03, 32'h04, 1'b0, 0, 1'b0);

    // Reset while holding a result in DONE.
    a_v[1] = 32'h22;
    b_v[1] = 32'h11;
    in_valid[1] = 1'b1;
    out_ready[1] = 1'b0;
    tick();
    in_valid[1] = 1'b0;
    n = 0;
    while (!out_valid[1] && n < 20) begin
      tick();
      n++;
    end
    check("done_reached", 64'(out_valid[1]), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset(1);

    // out_ready high while idle has no effect.
    out_ready[1] = 1'b1;
    repeat (3) tick();
    out_ready[1] = 1'b0;
    check("idle_out_ready", 64'(out_valid[1]), 64'd0);
    check("idle_out_ready_busy", 64'(busy[1]), 64'd0);

    // Randomized regression on all widths.
    for (int idx = 0; idx < 3; idx++) begin
      repeat (1000) begin
        do_txn(idx, $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
